// File: rtl/alu_arbiter_if.sv
// Bundle between the ALU arbiter, its two requesters and the shared ALU.
// slave is the arbiter's view; master is the requesters'/ALU environment's view.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [4:0]  req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [4:0]  req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        resp0_valid;
  logic        resp0_ready;
  logic        resp1_valid;
  logic        resp1_ready;
  logic [63:0] resp_data;
  logic [4:0]  alu_control;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [63:0] alu_c;
  logic        busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  resp0_ready, resp1_ready, alu_c,
    output req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data,
    output alu_control, alu_a, alu_b, busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output resp0_ready, resp1_ready, alu_c,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data,
    input  alu_control, alu_a, alu_b, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered 64-bit-result ALU between two
// requesters: accept one op, drive the ALU for a fixed latency, return the result.
module alu_arbiter #(
  parameter logic [4:0] NOP_OP    = 5'b00000,
  parameter logic [4:0] LONG_OP_A = 5'b01111,
  parameter logic [4:0] LONG_OP_B = 5'b10000,
  parameter int         SHORT_LAT = 2,
  parameter int         LONG_LAT  = 34
) (
  input logic         Clock,
  input logic         Clear,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;   // requester granted most recently
  logic        gid_q, gid_d;     // owner of the op in flight
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] data_q, data_d;

  logic        gnt;
  logic        sel_ready;
  logic        req0_ready, req1_ready;
  logic        resp0_valid, resp1_valid;
  logic [4:0]  alu_control;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  sel_op;

  function automatic logic [7:0] lat_minus_one(input logic [4:0] op);
    if (op == LONG_OP_A || op == LONG_OP_B) return 8'(LONG_LAT - 1);
    return 8'(SHORT_LAT - 1);
  endfunction

  // With both requesting, the one not granted last wins; otherwise the lone requester.
  assign gnt       = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;
  assign sel_op    = gnt ? bus.req1_op : bus.req0_op;
  assign sel_ready = gid_q ? bus.resp1_ready : bus.resp0_ready;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d     = state_q;
    last_d      = last_q;
    gid_d       = gid_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    data_d      = data_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    alu_control = NOP_OP;
    alu_a       = '0;
    alu_b       = '0;

    unique case (state_q)
      IDLE: begin
        req0_ready = bus.req0_valid && !gnt;
        req1_ready = bus.req1_valid && gnt;
        if (bus.req0_valid || bus.req1_valid) begin
          state_d = EXEC;
          gid_d   = gnt;
          last_d  = gnt;
          op_d    = sel_op;
          a_d     = gnt ? bus.req1_a : bus.req0_a;
          b_d     = gnt ? bus.req1_b : bus.req0_b;
          cnt_d   = lat_minus_one(sel_op);
        end
      end
      EXEC: begin
        alu_control = op_q;
        alu_a       = a_q;
        alu_b       = b_q;
        if (cnt_q == 8'd0) begin
          data_d  = bus.alu_c;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        resp0_valid = !gid_q;
        resp1_valid = gid_q;
        if (sel_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (!Clear) begin
      // NOTE: the latched operands and result are reset too, so a cleared
      // block never shows data from an aborted op.
      state_q <= IDLE;
      last_q  <= 1'b1;
      gid_q   <= 1'b0;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
    end
  end

  assign bus.req0_ready  = req0_ready;
  assign bus.req1_ready  = req1_ready;
  assign bus.resp0_valid = resp0_valid;
  assign bus.resp1_valid = resp1_valid;
  assign bus.resp_data   = data_q;
  assign bus.alu_control = alu_control;
  assign bus.alu_a       = alu_a;
  assign bus.alu_b       = alu_b;
  assign bus.busy        = (state_q != IDLE);

endmodule
